eq_gain_ramp: RTL and testbench

Gain-smoothing stage placed directly upstream of the ten-band equalizer. It holds the ten target gains written by the control side. It drives `gain_1`..`gain_10` into the equalizer, stepping each one toward its target by at most `RAMP_STEP` once per audio sample. This prevents zipper noise on gain changes and implements a click-free mute. A single shared comparator/adder is time-multiplexed across the bands by a scan state machine.

---
 rtl/eq_gain_ramp.sv | 183 ++++++++++++++++++
 tb/tb_eq_gain_ramp.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/eq_gain_ramp.sv
// Gain-smoothing stage ahead of the ten-band equalizer: holds target gains and
// slews each output gain toward its (mute-aware) target by RAMP_STEP per sample.
module eq_gain_ramp #(
    parameter int GAIN_WIDTH = 13,
    parameter int RAMP_STEP  = 16,
    parameter int GAIN_RESET = 341
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_tick,
    input  logic                         wr_en,
    input  logic [3:0]                   wr_band,
    input  logic signed [GAIN_WIDTH-1:0] wr_gain,
    input  logic                         mute,
    output logic signed [GAIN_WIDTH-1:0] gain_1,
    output logic signed [GAIN_WIDTH-1:0] gain_2,
    output logic signed [GAIN_WIDTH-1:0] gain_3,
    output logic signed [GAIN_WIDTH-1:0] gain_4,
    output logic signed [GAIN_WIDTH-1:0] gain_5,
    output logic signed [GAIN_WIDTH-1:0] gain_6,
    output logic signed [GAIN_WIDTH-1:0] gain_7,
    output logic signed [GAIN_WIDTH-1:0] gain_8,
    output logic signed [GAIN_WIDTH-1:0] gain_9,
    output logic signed [GAIN_WIDTH-1:0] gain_10,
    output logic                         busy,
    output logic                         wr_err,
    output logic                         overrun
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic signed [GAIN_WIDTH:0]   STEP_W = (GAIN_WIDTH+1)'(RAMP_STEP);
    localparam logic signed [GAIN_WIDTH-1:0] STEP_G = GAIN_WIDTH'(RAMP_STEP);
    localparam logic signed [GAIN_WIDTH-1:0] RST_G  = GAIN_WIDTH'(GAIN_RESET);

    state_t                         state_q, state_d;
    logic [3:0]                     idx_q, idx_d;
    logic                           pending_q, pending_d;
    logic                           dirty_q, dirty_d;
    logic                           busy_q, busy_d;
    logic                           wr_err_q, wr_err_d;
    logic                           overrun_q, overrun_d;
    logic                           mute_prev_q, mute_prev_d;
    logic signed [GAIN_WIDTH-1:0]   target_q [10];
    logic signed [GAIN_WIDTH-1:0]   target_d [10];
    logic signed [GAIN_WIDTH-1:0]   cur_q [10];
    logic signed [GAIN_WIDTH-1:0]   cur_d [10];

    logic                           wr_ok;
    logic                           change_ev;
    logic                           pass_exit;
    logic                           mismatch;
    logic signed [GAIN_WIDTH-1:0]   eff_sel;
    logic signed [GAIN_WIDTH-1:0]   cur_sel;
    logic signed [GAIN_WIDTH:0]     diff;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pending_d   = pending_q;
        dirty_d     = dirty_q;
        busy_d      = busy_q;
        overrun_d   = 1'b0;
        mute_prev_d = mute;
        target_d    = target_q;
        cur_d       = cur_q;
        pass_exit   = 1'b0;
        mismatch    = 1'b0;

        wr_ok     = wr_en && (wr_band < 4'd10);
        wr_err_d  = wr_en && (wr_band >= 4'd10);
        change_ev = wr_ok || (mute != mute_prev_q);

        if (wr_ok) begin
            target_d[wr_band] = wr_gain;
        end

        // Ramp datapath always reads the registered target, so a same-cycle
        // write to the band being processed only applies on the next pass.
        eff_sel = mute ? '0 : target_q[idx_q];
        cur_sel = cur_q[idx_q];
        diff    = {eff_sel[GAIN_WIDTH-1], eff_sel} - {cur_sel[GAIN_WIDTH-1], cur_sel};

        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (diff > STEP_W) begin
                    cur_d[idx_q] = cur_sel + STEP_G;
                end else if (diff < -STEP_W) begin
                    cur_d[idx_q] = cur_sel - STEP_G;
                end else begin
                    cur_d[idx_q] = eff_sel;
                end

                if (idx_q != 4'd9) begin
                    idx_d = idx_q + 4'd1;
                    if (sample_tick) begin
                        if (pending_q) begin
                            overrun_d = 1'b1;
                        end else begin
                            pending_d = 1'b1;
                        end
                    end
                end else begin
                    pass_exit = 1'b1;
                    idx_d     = '0;
                    pending_d = 1'b0;
                    if (!(pending_q || sample_tick)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        for (int unsigned k = 0; k < 10; k++) begin
            if (cur_d[k] != (mute ? '0 : target_q[k])) begin
                mismatch = 1'b1;
            end
        end

        if (pass_exit) begin
            dirty_d = 1'b0;
            busy_d  = mismatch || dirty_q || change_ev;
        end else begin
            if ((state_q == SCAN) && change_ev) begin
                dirty_d = 1'b1;
            end
            busy_d = busy_q || change_ev;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            dirty_q     <= 1'b0;
            busy_q      <= 1'b0;
            wr_err_q    <= 1'b0;
            overrun_q   <= 1'b0;
            mute_prev_q <= 1'b0;
            for (int unsigned k = 0; k < 10; k++) begin
                target_q[k] <= RST_G;
                cur_q[k]    <= RST_G;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            dirty_q     <= dirty_d;
            busy_q      <= busy_d;
            wr_err_q    <= wr_err_d;
            overrun_q   <= overrun_d;
            mute_prev_q <= mute_prev_d;
            target_q    <= target_d;
            cur_q       <= cur_d;
        end
    end

    assign gain_1  = cur_q[0];
    assign gain_2  = cur_q[1];
    assign gain_3  = cur_q[2];
    assign gain_4  = cur_q[3];
    assign gain_5  = cur_q[4];
    assign gain_6  = cur_q[5];
    assign gain_7  = cur_q[6];
    assign gain_8  = cur_q[7];
    assign gain_9  = cur_q[8];
    assign gain_10 = cur_q[9];
    assign busy    = busy_q;
    assign wr_err  = wr_err_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_eq_gain_ramp.sv
// Directed self-checking bench for eq_gain_ramp with hand-computed expectations.
module tb_eq_gain_ramp;

    logic               clk;
    logic               rst;
    logic               sample_tick;
    logic               wr_en;
    logic [3:0]         wr_band;
    logic signed [12:0] wr_gain;
    logic               mute;
    logic signed [12:0] gain_1, gain_2, gain_3, gain_4, gain_5;
    logic signed [12:0] gain_6, gain_7, gain_8, gain_9, gain_10;
    logic               busy;
    logic               wr_err;
    logic               overrun;
    logic signed [12:0] g [10];

    int checks = 0;
    int errors = 0;

    eq_gain_ramp #(
        .GAIN_WIDTH (13),
        .RAMP_STEP  (16),
        .GAIN_RESET (341)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .wr_en       (wr_en),
        .wr_band     (wr_band),
        .wr_gain     (wr_gain),
        .mute        (mute),
        .gain_1      (gain_1),
        .gain_2      (gain_2),
        .gain_3      (gain_3),
        .gain_4      (gain_4),
        .gain_5      (gain_5),
        .gain_6      (gain_6),
        .gain_7      (gain_7),
        .gain_8      (gain_8),
        .gain_9      (gain_9),
        .gain_10     (gain_10),
        .busy        (busy),
        .wr_err      (wr_err),
        .overrun     (overrun)
    );

    assign g[0] = gain_1;
    assign g[1] = gain_2;
    assign g[2] = gain_3;
    assign g[3] = gain_4;
    assign g[4] = gain_5;
    assign g[5] = gain_6;
    assign g[6] = gain_7;
    assign g[7] = gain_8;
    assign g[8] = gain_9;
    assign g[9] = gain_10;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int exp);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("%s_g%0d", tag, k + 1), g[k], exp);
        end
    endtask

    task automatic tick_pass();
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        step(11);
    endtask

    task automatic write(input logic [3:0] band, input int val);
        wr_en   = 1'b1;
        wr_band = band;
        wr_gain = 13'(val);
        step(1);
        wr_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sample_tick = 1'b0; wr_en = 1'b0;
        wr_band = '0; wr_gain = '0; mute = 1'b0;
        step(3);
        rst = 1'b0;
        chk_all("rst", 341);
        chk("rst_busy", busy, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_overrun", overrun, 0);

        tick_pass();
        chk_all("idle_pass", 341);
        chk("idle_busy", busy, 0);

        // Band 0 target 381: steps 357, 373, 381.
        write(4'd0, 381);
        chk("wr_busy", busy, 1);
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        chk("p1_e0_g1", gain_1, 341);
        step(1);
        chk("p1_e1_g1", gain_1, 357);
        step(10);
        chk("p1_busy", busy, 1);
        tick_pass();
        chk("p2_g1", gain_1, 373);
        tick_pass();
        chk("p3_g1", gain_1, 381);
        chk("p3_busy", busy, 0);

        // Mute ramp down.
        mute = 1'b1;
        step(1);
        chk("mute_busy", busy, 1);
        for (int p = 1; p <= 24; p++) begin
            tick_pass();
            chk($sformatf("mute_p%0d_g2", p), gain_2, (341 - 16 * p > 0) ? 341 - 16 * p : 0);
        end
        chk("mute_g1", gain_1, 0);
        chk("mute_g10", gain_10, 0);
        chk("mute_end_busy", busy, 0);

        // Unmute ramp up.
        mute = 1'b0;
        step(1);
        chk("unmute_busy", busy, 1);
        for (int p = 1; p <= 24; p++) begin
            tick_pass();
            chk($sformatf("unmute_p%0d_g2", p), gain_2, (16 * p < 341) ? 16 * p : 341);
        end
        chk("unmute_g1", gain_1, 381);
        chk("unmute_busy_end", busy, 0);

        // Ticks at offsets 0, 3, 5: one queued, one dropped.
        write(4'd0, 317);
        sample_tick = 1'b1; step(1);
        sample_tick = 1'b0; step(2);
        sample_tick = 1'b1; step(1);
        sample_tick = 1'b0; step(1);
        chk("q_e4_overrun", overrun, 0);
        sample_tick = 1'b1; step(1);
        sample_tick = 1'b0;
        chk("q_e5_overrun", overrun, 1);
        step(1);
        chk("q_e6_overrun", overrun, 0);
        step(4);
        chk("q_e10_g1", gain_1, 365);
        step(1);
        chk("q_e11_g1", gain_1, 349);
        step(10);
        chk("q_pass2_busy", busy, 1);
        tick_pass();
        tick_pass();
        chk("q_settle_g1", gain_1, 317);
        chk("q_settle_busy", busy, 0);

        // Out-of-range band write.
        write(4'd12, 100);
        chk("bad_wr_err", wr_err, 1);
        chk("bad_busy", busy, 0);
        step(1);
        chk("bad_wr_err_clr", wr_err, 0);
        chk("bad_g1", gain_1, 317);

        // Write band 4 while it is being processed.
        sample_tick = 1'b1; step(1);
        sample_tick = 1'b0; step(4);
        write(4'd4, -4096);
        chk("coll_g5", gain_5, 341);
        step(6);
        chk("coll_busy", busy, 1);
        tick_pass();
        chk("coll_next_g5", gain_5, 325);

        // Reset mid-scan at idx 5.
        sample_tick = 1'b1; step(1);
        sample_tick = 1'b0; step(5);
        chk("pre_rst_g5", gain_5, 309);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_all("mid_rst", 341);
        chk("mid_rst_busy", busy, 0);
        step(12);
        chk("post_rst_g1", gain_1, 341);
        chk("post_rst_busy", busy, 0);
        tick_pass();
        chk("post_rst_pass_g5", gain_5, 341);
        chk("post_rst_pass_g1", gain_1, 341);
        chk("post_rst_pass_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
